// File: rtl/des_pkg.sv
// Shared types and widths for the DES core arbiter slice.
package des_pkg;

   localparam int DES_BLK_W       = 64;
   localparam int DES_KEY_W       = 64;
   localparam int DES_TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      IDLE,
      LAUNCH,
      WAIT,
      RESP
   } arb_state_t;

endpackage

// File: rtl/des_core_arbiter_if.sv
// Requester/core bundle for des_core_arbiter.
// slave = arbiter side, master = requesters plus core.
interface des_core_arbiter_if #(
   parameter int N_REQ = 4
);
   import des_pkg::*;

   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0]           req_valid;
   logic [N_REQ-1:0]           req_ready;
   logic [N_REQ*DES_BLK_W-1:0] req_data;
   logic [N_REQ*DES_KEY_W-1:0] req_key;
   logic [N_REQ-1:0]           req_decrypt;
   logic [N_REQ-1:0]           rsp_valid;
   logic [N_REQ-1:0]           rsp_ready;
   logic [DES_BLK_W-1:0]       rsp_data;
   logic                       rsp_err;
   logic                       core_start;
   logic [DES_BLK_W-1:0]       core_data;
   logic [DES_KEY_W-1:0]       core_key;
   logic                       core_decrypt;
   logic                       core_done;
   logic [DES_BLK_W-1:0]       core_result;
   logic                       core_abort;
   logic                       busy;
   logic [OW-1:0]              owner;

   modport slave (
      input  req_valid, req_data, req_key, req_decrypt,
      input  rsp_ready, core_done, core_result,
      output req_ready, rsp_valid, rsp_data, rsp_err,
      output core_start, core_data, core_key, core_decrypt,
      output core_abort, busy, owner
   );

   modport master (
      output req_valid, req_data, req_key, req_decrypt,
      output rsp_ready, core_done, core_result,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
      input  core_start, core_data, core_key, core_decrypt,
      input  core_abort, busy, owner
   );

endinterface

// File: rtl/des_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after rr_ptr.
module des_rr_pick #(
   parameter int N = 4,
   parameter int W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] rr_ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx,
   output logic         any
);

   logic [W:0] pos;

   // Descending scan so the smallest offset from rr_ptr is written last.
   always_comb begin
      grant = '0;
      idx   = '0;
      pos   = '0;
      any   = |req;
      for (int k = N - 1; k >= 0; k--) begin
         pos = {1'b0, rr_ptr} + (W+1)'(k);
         if (pos >= (W+1)'(N)) pos = pos - (W+1)'(N);
         if (req[pos[W-1:0]]) begin
            grant             = '0;
            grant[pos[W-1:0]] = 1'b1;
            idx               = pos[W-1:0];
         end
      end
   end

endmodule

// File: rtl/des_core_arbiter.sv
// Round-robin arbiter sharing one iterative DES core among N_REQ requesters.
// Optional WAIT watchdog enabled by defining DES_ARB_TIMEOUT_EN.
module des_core_arbiter
   import des_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = DES_TIMEOUT_DEF
) (
   input logic                 clk,
   input logic                 reset,
   des_core_arbiter_if.slave   bus
);

   localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   arb_state_t           state;
   arb_state_t           state_n;
   logic [N_REQ-1:0]     grant;
   logic [OW-1:0]        pick;
   logic                 any;
   logic [OW-1:0]        rr_ptr;
   logic [OW-1:0]        owner;
   logic [DES_BLK_W-1:0] core_data;
   logic [DES_KEY_W-1:0] core_key;
   logic                 core_decrypt;
   logic [DES_BLK_W-1:0] rsp_data;
   logic                 rsp_err;
   logic                 tmo;
   logic                 core_abort;
   logic                 accept;
   logic                 rsp_take;

   des_rr_pick #(
      .N (N_REQ),
      .W (OW)
   ) u_pick (
      .req    (bus.req_valid),
      .rr_ptr (rr_ptr),
      .grant  (grant),
      .idx    (pick),
      .any    (any)
   );

   assign accept   = (state == IDLE) && any;
   assign rsp_take = (state == RESP) && bus.rsp_ready[owner];

`ifdef DES_ARB_TIMEOUT_EN
   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_CYCLES);

   logic [15:0] wait_cnt;

   // A done in the limit cycle wins over the watchdog.
   assign tmo = (state == WAIT) && !bus.core_done && (wait_cnt == TO_LIM);

   always_ff @(posedge clk) begin
      if (reset) begin
         wait_cnt   <= '0;
         core_abort <= 1'b0;
      end else begin
         core_abort <= tmo;
         if (state == LAUNCH) wait_cnt <= '0;
         else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
      end
   end
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;

   assign tmo        = 1'b0;
   assign core_abort = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (any) state_n = LAUNCH;
         LAUNCH:  state_n = WAIT;
         WAIT:    if (bus.core_done || tmo) state_n = RESP;
         RESP:    if (bus.rsp_ready[owner]) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_comb begin
      bus.req_ready  = (state == IDLE) ? grant : '0;
      bus.rsp_valid  = '0;
      if (state == RESP) bus.rsp_valid[owner] = 1'b1;
      bus.core_start = (state == LAUNCH);
      bus.busy       = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr       <= '0;
         owner        <= '0;
         core_data    <= '0;
         core_key     <= '0;
         core_decrypt <= 1'b0;
         rsp_data     <= '0;
         rsp_err      <= 1'b0;
      end else begin
         if (accept) begin
            owner        <= pick;
            core_data    <= bus.req_data[pick*DES_BLK_W +: DES_BLK_W];
            core_key     <= bus.req_key[pick*DES_KEY_W +: DES_KEY_W];
            core_decrypt <= bus.req_decrypt[pick];
         end
         if (state == WAIT) begin
            if (bus.core_done) begin
               rsp_data <= bus.core_result;
               rsp_err  <= 1'b0;
            end else if (tmo) begin
               rsp_data <= '0;
               rsp_err  <= 1'b1;
            end
         end
         if (rsp_take)
            rr_ptr <= (owner == OW'(N_REQ - 1)) ? '0 : owner + 1'b1;
      end
   end

   assign bus.owner        = owner;
   assign bus.core_data    = core_data;
   assign bus.core_key     = core_key;
   assign bus.core_decrypt = core_decrypt;
   assign bus.rsp_data     = rsp_data;
   assign bus.rsp_err      = rsp_err;
   assign bus.core_abort   = core_abort;

endmodule

// File: tb/tb_des_core_arbiter.sv
// Directed bench for des_core_arbiter with a hand-driven stub core.
module tb_des_core_arbiter;

`ifdef DES_ARB_TIMEOUT_EN
   localparam int TO = 20;
`else
   localparam int TO = 255;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   des_core_arbiter_if #(.N_REQ(4)) bus ();

   des_core_arbiter #(
      .N_REQ          (4),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      tick();
      tests++;
      if ({bus.busy, bus.core_start, bus.core_abort, bus.rsp_err} !== 4'b0) begin
         fails++;
         $display("FAIL reset_flags: got %b want 0000",
                  {bus.busy, bus.core_start, bus.core_abort, bus.rsp_err});
      end
      tests++;
      if ({bus.rsp_valid, bus.req_ready} !== 8'h00) begin
         fails++;
         $display("FAIL reset_vr: got %h want 00", {bus.rsp_valid, bus.req_ready});
      end
      tests++;
      if ({bus.rsp_data, bus.core_data, bus.core_key} !== 192'h0) begin
         fails++;
         $display("FAIL reset_data: got %h want 0",
                  {bus.rsp_data, bus.core_data, bus.core_key});
      end
      tests++;
      if ({bus.owner, bus.core_decrypt} !== 3'b0) begin
         fails++;
         $display("FAIL reset_owner: got %b want 000", {bus.owner, bus.core_decrypt});
      end
   endtask

   task automatic test_single;
      int extra;
      extra = 0;
      bus.req_data[63:0] = 64'h0123456789ABCDEF;
      bus.req_key[63:0]  = 64'h133457799BBCDFF1;
      bus.req_decrypt    = 4'b0000;
      bus.req_valid      = 4'b0001;
      #1;
      tests++;
      if ({bus.req_ready, bus.core_start} !== 5'b0001_0) begin
         fails++;
         $display("FAIL single_ready: got %b want 00010", {bus.req_ready, bus.core_start});
      end
      tick();
      bus.req_valid = 4'b0000;
      tests++;
      if ({bus.core_start, bus.busy, bus.owner, bus.core_decrypt} !== 5'b11_00_0) begin
         fails++;
         $display("FAIL single_start: got %b want 11000",
                  {bus.core_start, bus.busy, bus.owner, bus.core_decrypt});
      end
      tests++;
      if ({bus.core_data, bus.core_key} !== {64'h0123456789ABCDEF, 64'h133457799BBCDFF1}) begin
         fails++;
         $display("FAIL single_ops: got %h want %h", {bus.core_data, bus.core_key},
                  {64'h0123456789ABCDEF, 64'h133457799BBCDFF1});
      end
      for (int i = 0; i < 17; i++) begin
         tick();
         if (bus.core_start || bus.rsp_valid != 4'b0) extra++;
      end
      tests++;
      if (extra !== 0) begin
         fails++;
         $display("FAIL single_wait: got %0d bad cycles want 0", extra);
      end
      bus.core_done   = 1'b1;
      bus.core_result = 64'h85E813540F0AB405;
      tick();
      bus.core_done   = 1'b0;
      bus.core_result = 64'h0;
      tests++;
      if ({bus.rsp_valid, bus.rsp_err} !== 5'b0001_0) begin
         fails++;
         $display("FAIL single_rsp: got %b want 00010", {bus.rsp_valid, bus.rsp_err});
      end
      tests++;
      if (bus.rsp_data !== 64'h85E813540F0AB405) begin
         fails++;
         $display("FAIL single_data: got %h want 85e813540f0ab405", bus.rsp_data);
      end
      bus.rsp_ready = 4'b0001;
      tick();
      bus.rsp_ready = 4'b0000;
      tests++;
      if ({bus.busy, bus.rsp_valid} !== 5'b0) begin
         fails++;
         $display("FAIL single_idle: got %b want 00000", {bus.busy, bus.rsp_valid});
      end
   endtask

   task automatic test_round_robin;
      logic [3:0] expv;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int p = 0; p < 4; p++) begin
         bus.req_data[64*p +: 64] = 64'h1111_0000_0000_0000 * (p + 1);
         bus.req_key[64*p +: 64]  = 64'h0F0F_0F0F_0F0F_0F0F;
      end
      bus.req_valid = 4'b1111;
      for (int j = 0; j < 5; j++) begin
         expv = 4'b0001 << (j % 4);
         #1;
         tests++;
         if (bus.req_ready !== expv) begin
            fails++;
            $display("FAIL rr_grant%0d: got %b want %b", j, bus.req_ready, expv);
         end
         tick();
         tests++;
         if (bus.core_data !== 64'h1111_0000_0000_0000 * ((j % 4) + 1)) begin
            fails++;
            $display("FAIL rr_data%0d: got %h", j, bus.core_data);
         end
         tick();
         tests++;
         if (bus.req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL rr_busy_ready%0d: got %b want 0000", j, bus.req_ready);
         end
         bus.core_done   = 1'b1;
         bus.core_result = 64'hA0 + 64'(j);
         tick();
         bus.core_done = 1'b0;
         tests++;
         if ({bus.rsp_valid, bus.rsp_data} !== {expv, 64'hA0 + 64'(j)}) begin
            fails++;
            $display("FAIL rr_rsp%0d: got %b/%h want %b", j, bus.rsp_valid, bus.rsp_data, expv);
         end
         bus.rsp_ready = 4'b1111;
         tick();
         bus.rsp_ready = 4'b0000;
      end
      bus.req_valid = 4'b0000;
   endtask

   task automatic test_backpressure;
      bus.req_data[191:128] = 64'h2222_3333_4444_5555;
      bus.req_valid         = 4'b0100;
      #1;
      tests++;
      if (bus.req_ready !== 4'b0100) begin
         fails++;
         $display("FAIL bp_grant: got %b want 0100", bus.req_ready);
      end
      tick();
      bus.req_valid = 4'b0000;
      tick();
      bus.core_done   = 1'b1;
      bus.core_result = 64'hDEADBEEF0BADF00D;
      tick();
      bus.core_done   = 1'b0;
      bus.core_result = 64'h0;
      bus.rsp_ready   = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         tests++;
         if ({bus.rsp_valid, bus.rsp_data, bus.core_start} !==
             {4'b0100, 64'hDEADBEEF0BADF00D, 1'b0}) begin
            fails++;
            $display("FAIL bp_hold%0d: got %b/%h/%b", i, bus.rsp_valid, bus.rsp_data,
                     bus.core_start);
         end
         tick();
      end
      bus.rsp_ready = 4'b0100;
      tick();
      bus.rsp_ready = 4'b0000;
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL bp_release: got %b want 0", bus.busy);
      end
   endtask

   task automatic test_reset_mid;
      bus.req_valid = 4'b0001;
      #1;
      tests++;
      if (bus.req_ready !== 4'b0001) begin
         fails++;
         $display("FAIL rm_wrap: got %b want 0001", bus.req_ready);
      end
      tick();
      bus.req_valid = 4'b0000;
      tick();
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests++;
      if ({bus.busy, bus.core_start, bus.core_abort, bus.rsp_err, bus.rsp_valid} !== 8'h00) begin
         fails++;
         $display("FAIL rm_flags: got %b want 0", {bus.busy, bus.core_start,
                  bus.core_abort, bus.rsp_err, bus.rsp_valid});
      end
      tests++;
      if ({bus.rsp_data, bus.core_data, bus.owner} !== 130'h0) begin
         fails++;
         $display("FAIL rm_data: got %h want 0", {bus.rsp_data, bus.core_data, bus.owner});
      end
      tick();
      bus.core_done   = 1'b1;
      bus.core_result = 64'h5555AAAA5555AAAA;
      tick();
      bus.core_done = 1'b0;
      tick();
      tests++;
      if ({bus.busy, bus.rsp_valid} !== 5'b0) begin
         fails++;
         $display("FAIL rm_late_done: got %b want 00000", {bus.busy, bus.rsp_valid});
      end
      bus.req_valid = 4'b1010;
      #1;
      tests++;
      if (bus.req_ready !== 4'b0010) begin
         fails++;
         $display("FAIL rm_lowest: got %b want 0010", bus.req_ready);
      end
      tick();
      bus.req_valid = 4'b0000;
      tick();
      bus.core_done   = 1'b1;
      bus.core_result = 64'h0000000000000777;
      tick();
      bus.core_done = 1'b0;
      tests++;
      if ({bus.rsp_valid, bus.owner} !== 6'b0010_01) begin
         fails++;
         $display("FAIL rm_rsp: got %b want 001001", {bus.rsp_valid, bus.owner});
      end
      bus.rsp_ready = 4'b0010;
      tick();
      bus.rsp_ready = 4'b0000;
   endtask

   task automatic test_withdraw;
      bus.req_valid = 4'b0001;
      tick();
      bus.req_valid = 4'b0000;
      tick();
      bus.req_valid = 4'b1000;
      tick();
      tests++;
      if (bus.req_ready !== 4'b0000) begin
         fails++;
         $display("FAIL wd_ready: got %b want 0000", bus.req_ready);
      end
      tick();
      bus.req_valid   = 4'b0000;
      bus.core_done   = 1'b1;
      bus.core_result = 64'h0123012301230123;
      tick();
      bus.core_done = 1'b0;
      tests++;
      if (bus.rsp_valid !== 4'b0001) begin
         fails++;
         $display("FAIL wd_rsp: got %b want 0001", bus.rsp_valid);
      end
      bus.rsp_ready = 4'b0001;
      tick();
      bus.rsp_ready = 4'b0000;
      tick();
      tick();
      tests++;
      if ({bus.busy, bus.core_start, bus.req_ready} !== 6'b0) begin
         fails++;
         $display("FAIL wd_idle: got %b want 000000",
                  {bus.busy, bus.core_start, bus.req_ready});
      end
   endtask

`ifdef DES_ARB_TIMEOUT_EN
   task automatic test_timeout;
      logic found;
      found = 1'b0;
      bus.req_valid = 4'b0010;
      tick();
      bus.req_valid = 4'b0000;
      tick();
      for (int i = 0; i < 100 && !found; i++) begin
         tick();
         if (bus.core_abort) found = 1'b1;
      end
      tests++;
      if (found !== 1'b1) begin
         fails++;
         $display("FAIL to_abort: got %b want 1", found);
      end
      tests++;
      if ({bus.rsp_valid, bus.rsp_err, bus.rsp_data} !== {4'b0010, 1'b1, 64'h0}) begin
         fails++;
         $display("FAIL to_rsp: got %b/%b/%h want 0010/1/0", bus.rsp_valid, bus.rsp_err,
                  bus.rsp_data);
      end
      tick();
      tests++;
      if (bus.core_abort !== 1'b0) begin
         fails++;
         $display("FAIL to_pulse: got %b want 0", bus.core_abort);
      end
      bus.core_done   = 1'b1;
      bus.core_result = 64'hFFFFFFFFFFFFFFFF;
      tick();
      bus.core_done = 1'b0;
      tests++;
      if ({bus.rsp_err, bus.rsp_data} !== {1'b1, 64'h0}) begin
         fails++;
         $display("FAIL to_late: got %b/%h want 1/0", bus.rsp_err, bus.rsp_data);
      end
      bus.rsp_ready = 4'b0010;
      tick();
      bus.rsp_ready = 4'b0000;
      tests++;
      if (bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL to_idle: got %b want 0", bus.busy);
      end
   endtask
`endif

   initial begin
      bus.req_valid   = '0;
      bus.req_data    = '0;
      bus.req_key     = '0;
      bus.req_decrypt = '0;
      bus.rsp_ready   = '0;
      bus.core_done   = 1'b0;
      bus.core_result = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_reset_mid();
      test_withdraw();
`ifdef DES_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/des_core_arbiter.md
# des_core_arbiter

Shares one iterative DES core (plus its control FSM) among `N_REQ` requesters. Picks one pending request round-robin, latches its block, key and direction, and launches the core with a one-cycle start pulse. It then waits for the core's completion and returns the result to the requester that owns the job. It sits between the requester-side bus adapters and the DES core's start/done interface.

## Interface
- `N_REQ`, default 4: number of requester ports (2..8).
- `TIMEOUT_CYCLES`, default 255: watchdog limit in WAIT (used only with `DES_ARB_TIMEOUT_EN`).
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: reset is synchronous and active-high.
- `req_valid` in `N_REQ`: per-requester job request.
- `req_ready` out `N_REQ`: job accepted on the cycle where `req_valid[i] & req_ready[i]`.
- `req_data` in `N_REQ*64`: flattened plaintext/ciphertext; slice i = `[64*i +: 64]`.
- `req_key` in `N_REQ*64`: flattened 64-bit keys, parity bits included.
- `req_decrypt` in `N_REQ`: 1 = decrypt, 0 = encrypt.
- `rsp_valid` out `N_REQ`: result available to requester i.
- `rsp_ready` in `N_REQ`: requester i takes the result.
- `rsp_data` out 64: result, meaningful only while some `rsp_valid` bit is 1.
- `rsp_err` out 1: job timed out; qualified by `rsp_valid`.
- `core_start` out 1: one-cycle launch pulse.
- `core_data` out 64, `core_key` out 64, `core_decrypt` out 1: operands, held stable from LAUNCH through WAIT.
- `core_done` in 1: core completion pulse.
- `core_result` in 64: sampled on `core_done`.
- `core_abort` out 1: one-cycle pulse on timeout.
- `busy` out 1: high in any state other than IDLE.
- `owner` out `$clog2(N_REQ)`: index of the current job's requester.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- **IDLE:**
  - Winner = first i with `req_valid[i]`, searching from `rr_ptr` upward with wrap.
  - `req_ready[winner]` = 1 combinationally; all other `req_ready` bits are 0.
  - On a winner, latch its operands, set `owner`, go to LAUNCH. With no request, stay in IDLE.
- **LAUNCH:** `core_start`=1 for exactly this cycle, then go to WAIT. `core_done` is ignored in LAUNCH.
- **WAIT:** on `core_done`=1, capture `core_result` into `rsp_data` with `rsp_err`=0 and go to RESP.
- **RESP:**
  - `rsp_valid[owner]`=1; all other bits are 0.
  - On `rsp_ready[owner]`, go to IDLE and set `rr_ptr` = owner+1 mod `N_REQ`.
  - `rsp_ready` on non-owner ports is ignored.
- Requesters hold `req_valid` and payload stable until accepted. Dropping `req_valid` before acceptance is legal and withdraws the request.
- A requester whose response is pending is not re-granted until RESP exits.
- `core_done` outside WAIT is ignored, including a late done after a timeout.
- Reset values: state IDLE, `rr_ptr`=0, `owner`=0; every output 0, including `rsp_data`, `rsp_err` and `core_*`.
- Reset asserted mid-job drops the job silently: no response, and `core_abort` is not pulsed. The core must be reset by the same `reset`.

## Timing
- Accept at cycle t. `core_start` at t+1. WAIT from t+2.
- `core_done` at cycle d gives `rsp_valid` at d+1.
- `rsp_ready` at cycle r gives IDLE at r+1, where a new job can be accepted the same cycle.
- Minimum per-job overhead over core latency: 3 cycles.
- `req_ready` has a combinational path from `req_valid`. All other outputs are registered.

## Configuration
- `DES_ARB_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When it reaches `TIMEOUT_CYCLES` without `core_done`, pulse `core_abort` for one cycle and go to RESP with `rsp_data`=0 and `rsp_err`=1.
  - `core_done` in the same cycle as the limit wins: normal response.
- Undefined: no counter, `rsp_err` and `core_abort` tied 0, WAIT waits indefinitely.

## Structure
- Package `des_pkg` holds:
  - the `arb_state_t` enum (IDLE, LAUNCH, WAIT, RESP);
  - `DES_BLK_W`=64 and `DES_KEY_W`=64;
  - the default timeout constant.
- Sub-module `des_rr_pick`: combinational round-robin picker.
  - Inputs: `req` vector and `rr_ptr`.
  - Outputs: one-hot grant, its index, and a `any` flag.

## Test plan
- Single job, stub core with 18-cycle latency: requester 0 sends key 133457799BBCDFF1, data 0123456789ABCDEF, encrypt; stub returns 85E813540F0AB405. Expect:
  - `core_start` exactly 1 cycle after accept;
  - `rsp_valid[0]` with 85E813540F0AB405 one cycle after `core_done`;
  - `rsp_err`=0.
- All 4 ports request continuously: grants follow 0,1,2,3,0; no port is granted twice before the others are served.
- Backpressure: hold `rsp_ready[2]`=0 for 10 cycles. Expect `rsp_valid[2]` and `rsp_data` stable, no new `core_start`, and `rsp_ready[1]`=1 ignored.
- Reset asserted during WAIT:
  - next cycle: all outputs 0 and `busy`=0;
  - a `core_done` arriving 2 cycles later produces no response;
  - the next accept goes to the lowest-index valid port.
- With `DES_ARB_TIMEOUT_EN` and `TIMEOUT_CYCLES`=20, stub never asserts done. Expect:
  - `core_abort` pulse;
  - `rsp_valid[owner]` with `rsp_err`=1 and `rsp_data`=0;
  - a late `core_done` ignored.
- Withdrawal: requester 3 raises then drops `req_valid` while the arbiter is in WAIT. Expect no grant to 3 and IDLE after the current job.
